// File: rtl/lockstep_scoreboard.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lockstep_scoreboard
//
// N-channel lockstep comparator between the pipelined CPU and its reference
// model. Each channel has one elastic FIFO per side, so DUT and model may
// deliver the same sample at different times. When both FIFOs of a channel
// hold data, the heads are popped and compared. The block keeps compare and
// mismatch statistics, captures the first error and detects halt completion.
//
// Optional build macro: LOCKSTEP_SCOREBOARD_MASK_EN adds the cmp_mask input.
// A 1 in cmp_mask marks a don't-care bit. The mask is sampled in the compare
// cycle.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   dut_valid/data    per-channel DUT sample strobe and packed bundles
//   mdl_valid/data    per-channel model sample strobe and packed bundles
//   flush             per-channel clear of both FIFOs and of the lead timer
//   dut_hlt, mdl_hlt  halt reached writeback (latched, sticky)
//   state             0 IDLE, 1 RUN, 2 DONE, 3 FAIL
//   pass, fail        high in DONE / FAIL
//   err_code          0 none, 1 mismatch, 2 overflow, 3 timeout, 4 halt skew
//   err_ch            channel of the first error
//   err_dut/mdl_data  heads at the first mismatch (0 for other error codes)
//   cmp_count         total compares, wraps
//   mismatch_count    total mismatches, saturates at 0xFFFF
// -----------------------------------------------------------------------------
module lockstep_scoreboard #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        dut_valid,
    input  logic [NUM_CH*DATA_W-1:0] dut_data,
    input  logic [NUM_CH-1:0]        mdl_valid,
    input  logic [NUM_CH*DATA_W-1:0] mdl_data,
    input  logic [NUM_CH-1:0]        flush,
    input  logic                     dut_hlt,
    input  logic                     mdl_hlt,
`ifdef LOCKSTEP_SCOREBOARD_MASK_EN
    input  logic [NUM_CH*DATA_W-1:0] cmp_mask,
`endif
    output logic [1:0]               state,
    output logic                     pass,
    output logic                     fail,
    output logic [2:0]               err_code,
    output logic [3:0]               err_ch,
    output logic [DATA_W-1:0]        err_dut_data,
    output logic [DATA_W-1:0]        err_mdl_data,
    output logic [31:0]              cmp_count,
    output logic [15:0]              mismatch_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int SUM_W = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_MISMATCH  = 3'd1,
        ERR_OVERFLOW  = 3'd2,
        ERR_TIMEOUT   = 3'd3,
        ERR_HALT_SKEW = 3'd4
    } err_e;

    state_e                       state_q, state_d;
    logic [NUM_CH-1:0][PTR_W-1:0] dut_wr_q, dut_wr_d, dut_rd_q, dut_rd_d;
    logic [NUM_CH-1:0][PTR_W-1:0] mdl_wr_q, mdl_wr_d, mdl_rd_q, mdl_rd_d;
    logic [NUM_CH-1:0][CNT_W-1:0] dut_cnt_q, dut_cnt_d, mdl_cnt_q, mdl_cnt_d;
    logic [NUM_CH-1:0][TMR_W-1:0] tmr_q, tmr_d;
    logic [TMR_W-1:0]             skew_q, skew_d;
    logic                         dut_hlt_q, dut_hlt_d, mdl_hlt_q, mdl_hlt_d;
    logic [31:0]                  cmp_count_q, cmp_count_d;
    logic [15:0]                  mismatch_count_q, mismatch_count_d;
    err_e                         err_code_q, err_code_d;
    logic [3:0]                   err_ch_q, err_ch_d;
    logic [DATA_W-1:0]            err_dut_data_q, err_dut_data_d;
    logic [DATA_W-1:0]            err_mdl_data_q, err_mdl_data_d;

    logic [DATA_W-1:0] dut_mem_q [NUM_CH][DEPTH];
    logic [DATA_W-1:0] mdl_mem_q [NUM_CH][DEPTH];

    logic [NUM_CH-1:0]             dut_ne, mdl_ne, dut_full, mdl_full;
    logic [NUM_CH-1:0]             do_cmp, dut_push, mdl_push;
    logic [NUM_CH-1:0]             mis_vec, ovf_vec, tmo_vec;
    logic [NUM_CH-1:0][DATA_W-1:0] dut_head, mdl_head, mask_ch;
    logic                          skew_err, all_empty, err_hit;
    err_e                          err_new_code;
    logic [3:0]                    err_new_ch;
    logic [DATA_W-1:0]             err_new_dut, err_new_mdl;
    logic [SUM_W-1:0]              n_cmp, n_mis;
    logic [16:0]                   mis_sum;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign dut_ne[g]   = dut_cnt_q[g] != '0;
        assign mdl_ne[g]   = mdl_cnt_q[g] != '0;
        assign dut_full[g] = dut_cnt_q[g] == CNT_W'(DEPTH);
        assign mdl_full[g] = mdl_cnt_q[g] == CNT_W'(DEPTH);
        assign dut_head[g] = dut_mem_q[g][dut_rd_q[g]];
        assign mdl_head[g] = mdl_mem_q[g][mdl_rd_q[g]];
`ifdef LOCKSTEP_SCOREBOARD_MASK_EN
        assign mask_ch[g]  = cmp_mask[g*DATA_W +: DATA_W];
`else
        assign mask_ch[g]  = '0;
`endif
    end

    function automatic logic [3:0] lowest_idx(input logic [NUM_CH-1:0] vec);
        logic [3:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Per-channel FIFO pointers, compare strobes and lead timers.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        dut_wr_d  = dut_wr_q;
        dut_rd_d  = dut_rd_q;
        dut_cnt_d = dut_cnt_q;
        mdl_wr_d  = mdl_wr_q;
        mdl_rd_d  = mdl_rd_q;
        mdl_cnt_d = mdl_cnt_q;
        tmr_d     = tmr_q;
        do_cmp    = '0;
        dut_push  = '0;
        mdl_push  = '0;
        mis_vec   = '0;
        ovf_vec   = '0;
        tmo_vec   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (flush[i]) begin
                // Flush wins over any same-cycle push or compare on this channel.
                dut_wr_d[i]  = '0;
                dut_rd_d[i]  = '0;
                dut_cnt_d[i] = '0;
                mdl_wr_d[i]  = '0;
                mdl_rd_d[i]  = '0;
                mdl_cnt_d[i] = '0;
                tmr_d[i]     = '0;
            end else begin
                do_cmp[i]  = dut_ne[i] & mdl_ne[i];
                mis_vec[i] = do_cmp[i] & (|((dut_head[i] ^ mdl_head[i]) & ~mask_ch[i]));
                // A full FIFO still accepts a push when its head pops this cycle.
                dut_push[i] = dut_valid[i] & (~dut_full[i] | do_cmp[i]);
                mdl_push[i] = mdl_valid[i] & (~mdl_full[i] | do_cmp[i]);
                ovf_vec[i]  = (dut_valid[i] & ~dut_push[i]) | (mdl_valid[i] & ~mdl_push[i]);
                dut_wr_d[i]  = dut_wr_q[i] + PTR_W'(dut_push[i]);
                dut_rd_d[i]  = dut_rd_q[i] + PTR_W'(do_cmp[i]);
                dut_cnt_d[i] = dut_cnt_q[i] + CNT_W'(dut_push[i]) - CNT_W'(do_cmp[i]);
                mdl_wr_d[i]  = mdl_wr_q[i] + PTR_W'(mdl_push[i]);
                mdl_rd_d[i]  = mdl_rd_q[i] + PTR_W'(do_cmp[i]);
                mdl_cnt_d[i] = mdl_cnt_q[i] + CNT_W'(mdl_push[i]) - CNT_W'(do_cmp[i]);
                if (dut_ne[i] ^ mdl_ne[i]) begin
                    // Saturate so a long lead cannot wrap and re-arm.
                    if (tmr_q[i] != TMR_W'(TIMEOUT)) tmr_d[i] = tmr_q[i] + TMR_W'(1);
                    tmo_vec[i] = tmr_q[i] == TMR_W'(TIMEOUT - 1);
                end else begin
                    tmr_d[i] = '0;
                end
            end
        end
    end

    // Halt latches and halt-skew timer.
    always_comb begin
        dut_hlt_d = dut_hlt_q | dut_hlt;
        mdl_hlt_d = mdl_hlt_q | mdl_hlt;
        skew_d    = '0;
        skew_err  = 1'b0;
        if (dut_hlt_q ^ mdl_hlt_q) begin
            skew_d   = (skew_q == TMR_W'(TIMEOUT)) ? skew_q : skew_q + TMR_W'(1);
            skew_err = skew_q == TMR_W'(TIMEOUT - 1);
        end
    end

    // Statistics: several channels may compare in the same cycle.
    always_comb begin
        n_cmp = '0;
        n_mis = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n_cmp = n_cmp + SUM_W'(do_cmp[i]);
            n_mis = n_mis + SUM_W'(mis_vec[i]);
        end
        cmp_count_d      = cmp_count_q + 32'(n_cmp);
        mis_sum          = 17'(mismatch_count_q) + 17'(n_mis);
        mismatch_count_d = mis_sum[16] ? 16'hFFFF : mis_sum[15:0];
    end

    // Error arbitration: mismatch > overflow > timeout > halt skew, lowest channel first.
    always_comb begin
        err_hit      = 1'b1;
        err_new_code = ERR_NONE;
        err_new_ch   = '0;
        err_new_dut  = '0;
        err_new_mdl  = '0;
        if (|mis_vec) begin
            err_new_code = ERR_MISMATCH;
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (mis_vec[i]) begin
                    err_new_ch  = 4'(i);
                    err_new_dut = dut_head[i];
                    err_new_mdl = mdl_head[i];
                end
            end
        end else if (|ovf_vec) begin
            err_new_code = ERR_OVERFLOW;
            err_new_ch   = lowest_idx(ovf_vec);
        end else if (|tmo_vec) begin
            err_new_code = ERR_TIMEOUT;
            err_new_ch   = lowest_idx(tmo_vec);
        end else if (skew_err) begin
            err_new_code = ERR_HALT_SKEW;
        end else begin
            err_hit = 1'b0;
        end
    end

    // Completion looks at the post-edge occupancy so DONE lands on the same
    // edge that drains the last entry or latches the last halt.
    always_comb begin
        all_empty = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (dut_cnt_d[i] != '0 || mdl_cnt_d[i] != '0) all_empty = 1'b0;
        end
    end

    always_comb begin
        state_d        = state_q;
        err_code_d     = err_code_q;
        err_ch_d       = err_ch_q;
        err_dut_data_d = err_dut_data_q;
        err_mdl_data_d = err_mdl_data_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (err_hit) begin
                    state_d        = ST_FAIL;
                    err_code_d     = err_new_code;
                    err_ch_d       = err_new_ch;
                    err_dut_data_d = err_new_dut;
                    err_mdl_data_d = err_new_mdl;
                end else if (state_q == ST_IDLE) begin
                    if ((|dut_valid) || (|mdl_valid)) state_d = ST_RUN;
                end else if (dut_hlt_d && mdl_hlt_d && all_empty) begin
                    state_d = ST_DONE;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            dut_wr_q         <= '0;
            dut_rd_q         <= '0;
            dut_cnt_q        <= '0;
            mdl_wr_q         <= '0;
            mdl_rd_q         <= '0;
            mdl_cnt_q        <= '0;
            tmr_q            <= '0;
            skew_q           <= '0;
            dut_hlt_q        <= 1'b0;
            mdl_hlt_q        <= 1'b0;
            cmp_count_q      <= '0;
            mismatch_count_q <= '0;
            err_code_q       <= ERR_NONE;
            err_ch_q         <= '0;
            err_dut_data_q   <= '0;
            err_mdl_data_q   <= '0;
        end else begin
            state_q          <= state_d;
            dut_wr_q         <= dut_wr_d;
            dut_rd_q         <= dut_rd_d;
            dut_cnt_q        <= dut_cnt_d;
            mdl_wr_q         <= mdl_wr_d;
            mdl_rd_q         <= mdl_rd_d;
            mdl_cnt_q        <= mdl_cnt_d;
            tmr_q            <= tmr_d;
            skew_q           <= skew_d;
            dut_hlt_q        <= dut_hlt_d;
            mdl_hlt_q        <= mdl_hlt_d;
            cmp_count_q      <= cmp_count_d;
            mismatch_count_q <= mismatch_count_d;
            err_code_q       <= err_code_d;
            err_ch_q         <= err_ch_d;
            err_dut_data_q   <= err_dut_data_d;
            err_mdl_data_q   <= err_mdl_data_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and counts define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (dut_push[i]) dut_mem_q[i][dut_wr_q[i]] <= dut_data[i*DATA_W +: DATA_W];
            if (mdl_push[i]) mdl_mem_q[i][mdl_wr_q[i]] <= mdl_data[i*DATA_W +: DATA_W];
        end
    end

    assign state          = state_q;
    assign pass           = state_q == ST_DONE;
    assign fail           = state_q == ST_FAIL;
    assign err_code       = err_code_q;
    assign err_ch         = err_ch_q;
    assign err_dut_data   = err_dut_data_q;
    assign err_mdl_data   = err_mdl_data_q;
    assign cmp_count      = cmp_count_q;
    assign mismatch_count = mismatch_count_q;

endmodule

// File: tb/tb_lockstep_scoreboard.sv
`timescale 1ns/1ps
// Self-checking bench for lockstep_scoreboard: directed scenarios followed by
// a randomized phase checked against a queue-based reference model.
module tb_lockstep_scoreboard;

    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 64;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 1024;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH-1:0]        dut_valid, mdl_valid, flush;
    logic [NUM_CH*DATA_W-1:0] dut_data, mdl_data, cmp_mask;
    logic                     dut_hlt, mdl_hlt;
    logic [1:0]               state;
    logic                     pass, fail;
    logic [2:0]               err_code;
    logic [3:0]               err_ch;
    logic [DATA_W-1:0]        err_dut_data, err_mdl_data;
    logic [31:0]              cmp_count;
    logic [15:0]              mismatch_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    lockstep_scoreboard #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dut_valid      (dut_valid),
        .dut_data       (dut_data),
        .mdl_valid      (mdl_valid),
        .mdl_data       (mdl_data),
        .flush          (flush),
        .dut_hlt        (dut_hlt),
        .mdl_hlt        (mdl_hlt),
`ifdef LOCKSTEP_SCOREBOARD_MASK_EN
        .cmp_mask       (cmp_mask),
`endif
        .state          (state),
        .pass           (pass),
        .fail           (fail),
        .err_code       (err_code),
        .err_ch         (err_ch),
        .err_dut_data   (err_dut_data),
        .err_mdl_data   (err_mdl_data),
        .cmp_count      (cmp_count),
        .mismatch_count (mismatch_count)
    );

    // Reference model state for the randomized phase.
    logic [63:0] dq [NUM_CH][$];
    logic [63:0] mq [NUM_CH][$];
    logic [31:0] m_cmp;
    logic [15:0] m_mis;
    int          m_state, m_code, m_ch;
    logic [63:0] m_dd, m_md;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dut_valid = '0;
        mdl_valid = '0;
        dut_data  = '0;
        mdl_data  = '0;
        flush     = '0;
        cmp_mask  = '0;
        dut_hlt   = 1'b0;
        mdl_hlt   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic push_dut(input int ch, input logic [63:0] v);
        dut_valid[ch] = 1'b1;
        dut_data[ch*DATA_W +: DATA_W] = v;
    endtask

    task automatic push_mdl(input int ch, input logic [63:0] v);
        mdl_valid[ch] = 1'b1;
        mdl_data[ch*DATA_W +: DATA_W] = v;
    endtask

    // One cycle of the reference: flush clears, heads pop and compare, then
    // pushes land if there is room after the pop.
    task automatic model_cycle();
        int          code, ech;
        logic [63:0] a, b, ed, em;
        code = 0; ech = 0; ed = '0; em = '0;
        for (int ch = NUM_CH - 1; ch >= 0; ch--) begin
            if (flush[ch]) begin
                dq[ch].delete();
                mq[ch].delete();
            end else begin
                if (dq[ch].size() > 0 && mq[ch].size() > 0) begin
                    a = dq[ch].pop_front();
                    b = mq[ch].pop_front();
                    m_cmp++;
                    if (a != b) begin
                        if (m_mis != 16'hFFFF) m_mis++;
                        code = 1; ech = ch; ed = a; em = b;
                    end
                end
                if (dut_valid[ch]) begin
                    if (dq[ch].size() < DEPTH) dq[ch].push_back(dut_data[ch*DATA_W +: DATA_W]);
                    else if (code != 1) begin code = 2; ech = ch; end
                end
                if (mdl_valid[ch]) begin
                    if (mq[ch].size() < DEPTH) mq[ch].push_back(mdl_data[ch*DATA_W +: DATA_W]);
                    else if (code != 1) begin code = 2; ech = ch; end
                end
            end
        end
        // Downward scan leaves the lowest channel, but an overflow must not
        // displace a mismatch found on a higher channel.
        if (code == 1) begin
            for (int ch = NUM_CH - 1; ch >= 0; ch--) begin
                // already resolved: lowest mismatching channel was the last to write
            end
        end
        if ((m_state == 0 || m_state == 1) && code != 0) begin
            m_state = 3; m_code = code; m_ch = ech;
            m_dd = (code == 1) ? ed : 64'd0;
            m_md = (code == 1) ? em : 64'd0;
        end else if (m_state == 0 && ((|dut_valid) || (|mdl_valid))) begin
            m_state = 1;
        end
    endtask

    initial begin
        int          dseq [NUM_CH];
        int          mseq [NUM_CH];
        logic [63:0] v;

        do_reset();
        // Reset state.
        check("rst state", 64'(state), 64'd0);
        check("rst pass", 64'(pass), 64'd0);
        check("rst fail", 64'(fail), 64'd0);
        check("rst err_code", 64'(err_code), 64'd0);
        check("rst err_ch", 64'(err_ch), 64'd0);
        check("rst err_dut", 64'(err_dut_data), 64'd0);
        check("rst err_mdl", 64'(err_mdl_data), 64'd0);
        check("rst cmp", 64'(cmp_count), 64'd0);
        check("rst mis", 64'(mismatch_count), 64'd0);

        // Matched pair on ch0: compared one edge after the push.
        push_dut(0, 64'h1234); push_mdl(0, 64'h1234);
        step(); clear_inputs();
        check("t1 cmp before", 64'(cmp_count), 64'd0);
        check("t1 state run", 64'(state), 64'd1);
        step();
        check("t1 cmp", 64'(cmp_count), 64'd1);
        check("t1 mis", 64'(mismatch_count), 64'd0);
        check("t1 state", 64'(state), 64'd1);

        // Flush ch3 holding three entries (and a same-cycle push), then one pair.
        for (int i = 0; i < 3; i++) begin
            push_dut(3, 64'(i + 1)); step(); clear_inputs();
        end
        flush[3] = 1'b1; push_dut(3, 64'h7);
        step(); clear_inputs();
        push_dut(3, 64'h5); push_mdl(3, 64'h5);
        step(); clear_inputs();
        step();
        check("t4 cmp", 64'(cmp_count), 64'd2);
        check("t4 mis", 64'(mismatch_count), 64'd0);
        check("t4 err_code", 64'(err_code), 64'd0);
        repeat (5) step();
        check("t4 cmp settled", 64'(cmp_count), 64'd2);
        check("t4 state", 64'(state), 64'd1);

        // Both halts with everything drained -> DONE on the next edge, sticky.
        dut_hlt = 1'b1; mdl_hlt = 1'b1;
        step(); clear_inputs();
        check("t5 state done", 64'(state), 64'd2);
        check("t5 pass", 64'(pass), 64'd1);
        check("t5 fail", 64'(fail), 64'd0);
        push_dut(0, 64'h1); push_mdl(0, 64'h2);
        step(); clear_inputs(); step();
        check("t5 done sticky", 64'(state), 64'd2);
        check("t5 done err_code", 64'(err_code), 64'd0);

        // Reset mid-run with data in a FIFO.
        for (int i = 0; i < 3; i++) begin
            push_dut(1, 64'hDEAD); step();
        end
        rst_n = 1'b0;
        step();
        check("mid rst state", 64'(state), 64'd0);
        check("mid rst cmp", 64'(cmp_count), 64'd0);
        check("mid rst pass", 64'(pass), 64'd0);
        rst_n = 1'b1; clear_inputs();
        push_dut(1, 64'h9); push_mdl(1, 64'h9);
        step(); clear_inputs(); step();
        check("mid rst fifo empty cmp", 64'(cmp_count), 64'd1);
        check("mid rst fifo empty mis", 64'(mismatch_count), 64'd0);

        // Only the DUT halts: halt skew after TIMEOUT cycles.
        dut_hlt = 1'b1;
        step(); clear_inputs();
        repeat (TIMEOUT - 1) step();
        check("t5b not yet", 64'(state), 64'd1);
        step();
        check("t5b state", 64'(state), 64'd3);
        check("t5b err_code", 64'(err_code), 64'd4);
        check("t5b err_ch", 64'(err_ch), 64'd0);
        check("t5b err_dut", 64'(err_dut_data), 64'd0);
        check("t5b fail", 64'(fail), 64'd1);

        // Skewed mismatch on ch2.
        do_reset();
        push_dut(2, 64'hA); step(); clear_inputs();
        repeat (3) step();
        push_mdl(2, 64'hB); step(); clear_inputs();
        check("t2 cmp before", 64'(cmp_count), 64'd0);
        check("t2 state before", 64'(state), 64'd1);
        step();
        check("t2 state", 64'(state), 64'd3);
        check("t2 err_code", 64'(err_code), 64'd1);
        check("t2 err_ch", 64'(err_ch), 64'd2);
        check("t2 err_dut", 64'(err_dut_data), 64'hA);
        check("t2 err_mdl", 64'(err_mdl_data), 64'hB);
        check("t2 mis", 64'(mismatch_count), 64'd1);

        // Overflow on the ninth unanswered push.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            push_dut(1, 64'(i)); step(); clear_inputs();
        end
        check("t3 full no err", 64'(err_code), 64'd0);
        push_dut(1, 64'h99); step(); clear_inputs();
        check("t3 state", 64'(state), 64'd3);
        check("t3 err_code", 64'(err_code), 64'd2);
        check("t3 err_ch", 64'(err_ch), 64'd1);
        check("t3 err_dut", 64'(err_dut_data), 64'd0);

        // Per-channel timeout.
        do_reset();
        push_dut(0, 64'h3); step(); clear_inputs();
        repeat (TIMEOUT - 1) step();
        check("tmo not yet", 64'(state), 64'd1);
        step();
        check("tmo state", 64'(state), 64'd3);
        check("tmo err_code", 64'(err_code), 64'd3);
        check("tmo err_ch", 64'(err_ch), 64'd0);

        // Same-cycle mismatch on ch2/ch3 and overflow on ch0.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            push_dut(0, 64'(i));
            if (i == DEPTH - 1) begin
                push_dut(2, 64'h5); push_mdl(2, 64'h6);
                push_dut(3, 64'h1); push_mdl(3, 64'h2);
            end
            step(); clear_inputs();
        end
        push_dut(0, 64'h99); step(); clear_inputs();
        check("prio err_code", 64'(err_code), 64'd1);
        check("prio err_ch", 64'(err_ch), 64'd2);
        check("prio err_dut", 64'(err_dut_data), 64'h5);
        check("prio err_mdl", 64'(err_mdl_data), 64'h6);
        check("prio mis", 64'(mismatch_count), 64'd2);

        // Masked compare (bit 8 don't-care when the mask build is used).
        do_reset();
        push_dut(0, 64'h00FF); push_mdl(0, 64'h01FF);
        step(); clear_inputs();
        cmp_mask[8] = 1'b1;
        step(); clear_inputs();
`ifdef LOCKSTEP_SCOREBOARD_MASK_EN
        check("mask mis", 64'(mismatch_count), 64'd0);
        check("mask state", 64'(state), 64'd1);
`else
        check("mask mis", 64'(mismatch_count), 64'd1);
        check("mask state", 64'(state), 64'd3);
`endif

        // Statistics in FAIL; mismatch_count saturates, cmp_count keeps counting.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                push_dut(ch, 64'(i)); push_mdl(ch, 64'(i) ^ 64'h8000);
            end
            step();
        end
        clear_inputs(); step();
        check("stat cmp 400", 64'(cmp_count), 64'd400);
        check("stat mis 400", 64'(mismatch_count), 64'd400);
        check("stat err_ch", 64'(err_ch), 64'd0);
        check("stat err_mdl", 64'(err_mdl_data), 64'h8000);
        for (int i = 0; i < 16300; i++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                push_dut(ch, 64'(i)); push_mdl(ch, 64'(i) ^ 64'h1);
            end
            step();
        end
        clear_inputs(); step();
        check("stat cmp 65600", 64'(cmp_count), 64'd65600);
        check("stat mis sat", 64'(mismatch_count), 64'hFFFF);

        // Randomized phase against the queue model.
        do_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            dq[ch].delete(); mq[ch].delete(); dseq[ch] = 0; mseq[ch] = 0;
        end
        m_cmp = '0; m_mis = '0; m_state = 0; m_code = 0; m_ch = 0; m_dd = '0; m_md = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            clear_inputs();
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ($urandom_range(0, 1) == 1) begin
                    push_dut(ch, (64'(ch) << 32) | 64'(dseq[ch]));
                    dseq[ch]++;
                end
                if ($urandom_range(0, 1) == 1) begin
                    v = (64'(ch) << 32) | 64'(mseq[ch]);
                    if ($urandom_range(0, 149) == 0) v = v ^ 64'h10;
                    push_mdl(ch, v);
                    mseq[ch]++;
                end
                if ($urandom_range(0, 59) == 0) flush[ch] = 1'b1;
            end
            model_cycle();
            step();
            check("rnd cmp", 64'(cmp_count), 64'(m_cmp));
            check("rnd mis", 64'(mismatch_count), 64'(m_mis));
            check("rnd state", 64'(state), 64'(m_state));
            check("rnd err_code", 64'(err_code), 64'(m_code));
            check("rnd err_ch", 64'(err_ch), 64'(m_ch));
            check("rnd err_dut", 64'(err_dut_data), m_dd);
            check("rnd err_mdl", 64'(err_mdl_data), m_md);
        end
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lockstep_scoreboard.md
Name: lockstep_scoreboard

Overview:
- Synthesizable, parametrised N-channel lockstep comparator between the pipelined CPU and its reference model.
- Successor to the per-stage compare tasks; it tolerates latency skew between DUT and model through per-channel elastic FIFOs.
- Tracks compare and mismatch statistics, captures the first failure, and detects halt completion or timeout.
- Sits beside the core; each pipeline stage (IF/ID, ID/EX, EX/MEM, MEM/WB) drives one channel pair.

Parameters:
NUM_CH, 4, number of compared channels (1..16)
DATA_W, 64, width of each channel's packed signal bundle
DEPTH, 8, per-side FIFO depth per channel, power of two >= 2
TIMEOUT, 1024, max cycles one side may lead the other before failing

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
dut_valid  in  NUM_CH  per-channel DUT sample strobe
dut_data  in  NUM_CH*DATA_W  DUT bundles, channel i at [i*DATA_W +: DATA_W]
mdl_valid  in  NUM_CH  per-channel model sample strobe
mdl_data  in  NUM_CH*DATA_W  model bundles, same packing
flush  in  NUM_CH  per-channel clear of both FIFOs (pipeline flush)
dut_hlt  in  1  DUT halt reached writeback
mdl_hlt  in  1  model halt reached writeback
state  out  2  0 IDLE, 1 RUN, 2 DONE, 3 FAIL
pass  out  1  high in DONE
fail  out  1  high in FAIL
err_code  out  3  0 none, 1 mismatch, 2 overflow, 3 timeout, 4 halt skew
err_ch  out  4  channel of first error
err_dut_data  out  DATA_W  DUT head at first mismatch
err_mdl_data  out  DATA_W  model head at first mismatch
cmp_count  out  32  total compares, wraps
mismatch_count  out  16  total mismatches, saturates at 0xFFFF

Behaviour:
- Reset: all outputs 0, state IDLE, FIFOs empty, halt latches clear, timers 0.
- Push: on a posedge with valid high, data is written to that side's FIFO.
- Push while full with a pop in the same cycle: legal.
- Push while full with no pop: the sample is dropped and raises overflow.
- Compare: in any cycle where both FIFOs of channel i are non-empty, pop both heads and compare them.
  - The result is registered at that edge.
  - Minimum latency: both pushed at edge k, compared at edge k+1; counters reflect the compare after edge k+1.
- Each compare increments cmp_count; each unequal compare also increments mismatch_count.
- Flush[i]: empties both FIFOs of channel i and clears timer i.
  - Flush overrides any same-cycle push or compare on channel i; no count is taken.
- Timer i: increments while exactly one FIFO of channel i is non-empty, else clears.
  - Reaching TIMEOUT raises timeout.
- Halt latches: dut_hlt and mdl_hlt are each sticky.
  - If exactly one latch is set for TIMEOUT consecutive cycles, raise halt skew.
- State machine:
  - IDLE -> RUN on any valid bit.
  - RUN -> DONE when both halt latches are set and all FIFOs are empty.
  - IDLE/RUN -> FAIL on the first error.
  - DONE and FAIL are sticky until reset.
- FAIL behaviour:
  - err_code, err_ch and err_*_data freeze at the first error.
  - Counters keep running; compares continue so the statistics stay complete.
- err_*_data are valid only for mismatch; they are 0 for other error codes.
- Error priority, same cycle: mismatch > overflow > timeout > halt skew; within a type, the lowest channel index wins.
- An error in the same cycle as the DONE condition goes to FAIL.
- Reset mid-run: returns to the reset state on the next edge regardless of FIFO contents.

Optional Feature:
- Macro: LOCKSTEP_SCOREBOARD_MASK_EN.
- When defined:
  - Adds input cmp_mask, NUM_CH*DATA_W bits.
  - A 1 marks a don't-care bit for that channel; masked bits are excluded from equality.
  - cmp_mask is sampled in the compare cycle.
- When undefined:
  - The port is absent and all bits are compared.

Test Plan:
1. ch0: DUT and model each push 0x1234 at the same edge -> one edge later cmp_count=1, mismatch_count=0, state=RUN.
2. ch2: DUT pushes 0xA at edge 5, model pushes 0xB at edge 9 -> compare at edge 10; state=FAIL, err_code=1, err_ch=2, err_dut_data=0xA, err_mdl_data=0xB.
3. DEPTH=8: DUT pushes 9 samples on ch1 with no model pushes -> 9th push raises err_code=2, err_ch=1.
4. ch3: DUT holds 3 entries, flush[3] asserted, then both sides push 0x5 -> exactly one compare, no mismatch, no timeout.
5. All channels drained, dut_hlt and mdl_hlt pulsed -> state=DONE and pass=1 on the next edge.
   - Same bench with only dut_hlt -> FAIL, err_code=4, after TIMEOUT cycles.
6. With LOCKSTEP_SCOREBOARD_MASK_EN: DUT 0x00FF vs model 0x01FF, mask bit 8 set -> no mismatch.
   - Same stimulus with the macro undefined -> mismatch_count=1.
